// File: rtl/avr_uart_tx.sv
// avr_uart_tx: FIFO-buffered 8N1 transmitter to the AVR with Rx-busy flow control
module avr_uart_tx #(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_AW = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [7:0] tx_data,
  input  logic tx_valid,
  output logic tx_ready,
  input  logic avr_rx_busy,
  output logic avr_rx,
  output logic tx_busy,
  output logic [FIFO_AW:0] fifo_count
);
  localparam int TW = $clog2(CLK_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic [1:0] sync_q, sync_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic avr_rx_q, avr_rx_d;
  logic push, pop, tick, busy_s;
  assign tx_ready = !cnt_q[FIFO_AW];
  assign tx_busy = state_q != IDLE;
  assign avr_rx = avr_rx_q;
  assign fifo_count = cnt_q;
  always_comb begin
    busy_s = sync_q[1];
    push = tx_valid && tx_ready;
    pop = state_q == IDLE && cnt_q != '0 && !busy_s;
    tick = tmr_q == TW'(CLK_PER_BIT - 1);
    sync_d = {sync_q[0], avr_rx_busy};
    wr_d = push ? wr_q + FIFO_AW'(1) : wr_q;
    rd_d = pop ? rd_q + FIFO_AW'(1) : rd_q;
    cnt_d = cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    tmr_d = (tick || state_q == IDLE) ? '0 : tmr_q + TW'(1);
    state_d = state_q;
    idx_d = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = START;
        shift_d = mem_q[rd_q];
      end
      START: if (tick) begin
        state_d = DATA;
        idx_d = '0;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    avr_rx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      sync_q <= '0;
      tmr_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      avr_rx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      sync_q <= sync_d;
      tmr_q <= tmr_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      avr_rx_q <= avr_rx_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= tx_data;
endmodule

// File: tb/tb_avr_uart_tx.sv
// tb_avr_uart_tx: scoreboard bench decoding the serial line against accepted bytes
module tb_avr_uart_tx;
  localparam int CPB = 4;
  localparam int AW = 2;
  logic clk, rst_n, tx_valid, tx_ready, avr_rx_busy, avr_rx, tx_busy;
  logic [7:0] tx_data;
  logic [AW:0] fifo_count;
  int tests, fails, cyc, frames;
  logic [7:0] exp_q[$];
  int starts[$];
  avr_uart_tx #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .avr_rx_busy(avr_rx_busy), .avr_rx(avr_rx),
    .tx_busy(tx_busy), .fifo_count(fifo_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask
  task automatic push(input logic [7:0] b, output int acc);
    logic ok;
    int n;
    n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    do begin
      ok = tx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 5000);
    tx_valid = 1'b0;
    acc = cyc;
    if (ok) exp_q.push_back(b);
    else chk("push_accepted", 0, 1);
  endtask
  task automatic until_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_frames(input int k, input int budget);
    int n;
    n = 0;
    while (frames < k && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("frames_seen", frames, k);
  endtask
  initial begin : monitor
    logic s [10*CPB];
    logic [7:0] rb;
    logic bsy, shape;
    int n, st;
    n = 0;
    frames = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) n = 0;
      else if (n < 0) begin
        chk("idle_gap", {avr_rx, tx_busy}, 2);
        n = 0;
      end else if (n > 0 || avr_rx === 1'b0) begin
        if (n == 0) begin
          st = cyc;
          bsy = 1'b1;
        end
        s[n] = avr_rx;
        bsy &= tx_busy;
        n++;
        if (n == 10*CPB) begin
          shape = s[0] == 1'b0 && s[9*CPB] == 1'b1;
          for (int b = 0; b < 10; b++)
            for (int j = 1; j < CPB; j++)
              if (s[b*CPB+j] !== s[b*CPB]) shape = 1'b0;
          for (int i = 0; i < 8; i++) rb[i] = s[(i+1)*CPB];
          chk("frame_shape", shape, 1);
          chk("frame_tx_busy", bsy, 1);
          chk("frame_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("frame_byte", rb, exp_q.pop_front());
          starts.push_back(st);
          frames++;
          n = -1;
        end
      end
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin : stim
    int a0, a1, a2, f0, r, n;
    logic [7:0] b5;
    logic ok, done;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    avr_rx_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_avr_rx", avr_rx, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_tx_ready", tx_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    f0 = frames;
    push(8'hA5, a0);
    wait_frames(f0 + 1, 100);
    chk("a5_latency", starts[f0], a0 + 1);
    f0 = frames;
    push(8'h00, a0);
    push(8'hFF, a1);
    push(8'h55, a2);
    chk("burst_count_peak", fifo_count, 2);
    wait_frames(f0 + 3, 200);
    chk("burst_latency", starts[f0], a0 + 1);
    chk("burst_gap1", starts[f0+1] - starts[f0], 10*CPB + 1);
    chk("burst_gap2", starts[f0+2] - starts[f0+1], 10*CPB + 1);
    f0 = frames;
    avr_rx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push(8'h3C, a0);
    repeat (100) @(posedge clk);
    #1;
    chk("flow_line_high", avr_rx, 1);
    chk("flow_count", fifo_count, 1);
    chk("flow_no_frame", frames, f0);
    avr_rx_busy = 1'b0;
    r = cyc;
    wait_frames(f0 + 1, 100);
    chk("flow_release_latency", starts[f0], r + 3);
    f0 = frames;
    push(8'h81, a0);
    push(8'h42, a1);
    until_cyc(a0 + 1 + 4*CPB + CPB/2);
    avr_rx_busy = 1'b1;
    until_cyc(a0 + 60);
    avr_rx_busy = 1'b0;
    r = cyc;
    wait_frames(f0 + 2, 200);
    chk("midbusy_first_start", starts[f0], a0 + 1);
    chk("midbusy_second_start", starts[f0+1], r + 3);
    f0 = frames;
    avr_rx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) push(8'($urandom), a0);
    b5 = 8'($urandom);
    tx_data = b5;
    tx_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("full_tx_ready", tx_ready, 0);
    chk("full_count", fifo_count, 4);
    chk("full_no_frame", frames, f0);
    avr_rx_busy = 1'b0;
    n = 0;
    do begin
      ok = tx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 500);
    tx_valid = 1'b0;
    chk("full_fifth_accepted", ok, 1);
    if (ok) exp_q.push_back(b5);
    wait_frames(f0 + 5, 5*(10*CPB+1) + 50);
    f0 = frames;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          push(8'($urandom), a0);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          repeat ($urandom_range(1, 60)) @(posedge clk);
          #2 avr_rx_busy = $urandom_range(0, 3) == 0;
        end
        avr_rx_busy = 1'b0;
      end
    join
    wait_frames(f0 + 24, 3000);
    chk("random_drained", exp_q.size(), 0);
    f0 = frames;
    push(8'hC3, a0);
    push(8'h11, a1);
    push(8'h22, a2);
    until_cyc(a0 + 1 + 6*CPB + 1);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_avr_rx", avr_rx, 1);
    chk("midrst_tx_busy", tx_busy, 0);
    chk("midrst_fifo_count", fifo_count, 0);
    chk("midrst_tx_ready", tx_ready, 1);
    repeat (200) @(posedge clk);
    #1;
    chk("midrst_no_frames", frames, f0);
    chk("midrst_line_high", avr_rx, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
